// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// keypad_pkg - shared key map, candidate encoding and FSM states (rev 1.0)
// ============================================================================
package keypad_pkg;

  // Indexed {col, row}; row 0 is the top row of the keypad.
  localparam logic [15:0][3:0] C_KEY_MAP = {
    4'hD, 4'hC, 4'hB, 4'hA,   // c3
    4'hE, 4'h9, 4'h6, 4'h3,   // c2
    4'hF, 4'h8, 4'h5, 4'h2,   // c1
    4'h0, 4'h7, 4'h4, 4'h1    // c0
  };

  // Candidate = {valid, code}; NONE is the only encoding with valid clear.
  localparam logic [4:0] C_CAND_NONE = 5'b0_0000;

  typedef enum logic [0:0] {
    ST_RELEASED = 1'b0,
    ST_PRESSED  = 1'b1
  } kp_state_t;

endpackage
`default_nettype wire

// File: rtl/keypad_debounce.sv
`default_nettype none
// ============================================================================
// keypad_debounce - scan-level match counter and press/release FSM (rev 1.0)
// ============================================================================
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scan_done,
  input  logic [4:0] candidate,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam logic [3:0] C_STABLE = 4'(DEBOUNCE_SCANS);

  kp_state_t  r_state;
  kp_state_t  w_state_next;
  logic [4:0] r_prev;
  logic [3:0] r_match;
  logic [3:0] w_match_next;
  logic [3:0] r_code;
  logic [3:0] w_code_next;
  logic       r_valid;
  logic       w_valid_next;
  logic       w_stable;

  always_comb begin
    w_match_next = r_match;
    if (scan_done) begin
      if (candidate != r_prev) begin
        w_match_next = 4'd1;
      end else if (r_match < C_STABLE) begin
        w_match_next = r_match + 4'd1;
      end
    end
    w_stable = scan_done && (w_match_next == C_STABLE);
  end

  // Acting on the post-increment count lets the event land one edge after scan end.
  always_comb begin
    w_state_next = r_state;
    w_code_next  = r_code;
    w_valid_next = 1'b0;
    case (r_state)
      ST_RELEASED: begin
        if (w_stable && candidate[4]) begin
          w_state_next = ST_PRESSED;
          w_code_next  = candidate[3:0];
          w_valid_next = 1'b1;
        end
      end
      ST_PRESSED: begin
        if (w_stable && !candidate[4]) begin
          w_state_next = ST_RELEASED;
        end else if (w_stable && (candidate[3:0] != r_code)) begin
          w_code_next  = candidate[3:0];
          w_valid_next = 1'b1;
        end
      end
      default: w_state_next = ST_RELEASED;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_RELEASED;
      r_prev  <= C_CAND_NONE;
      r_match <= 4'd0;
      r_code  <= 4'd0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_match <= w_match_next;
      r_code  <= w_code_next;
      r_valid <= w_valid_next;
      if (scan_done) begin
        r_prev <= candidate;
      end
    end
  end

  assign key_code  = r_code;
  assign key_valid = r_valid;
  assign key_held  = (r_state == ST_PRESSED);

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// keypad_scanner - 4x4 keypad column scan, ghost reject and debounce (rev 1.0)
// ============================================================================
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int               DIV_W      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] C_DIV_ONE  = DIV_W'(1);

  logic [3:0]       r_row_meta;
  logic [3:0]       r_row_sync;
  logic [1:0]       r_col_idx;
  logic [DIV_W-1:0] r_div_cnt;
  logic [11:0]      r_hits;
  logic [4:0]       r_cand;
  logic             r_scan_done;
  logic             w_slot_end;
  logic [15:0]      w_scan;
  logic [4:0]       w_count;
  logic [3:0]       w_idx;
  logic [4:0]       w_cand;

  assign w_slot_end = (r_div_cnt == C_DIV_LAST);
  assign col        = ~(4'b0001 << r_col_idx);

  // Columns 0..2 come from the accumulator; column 3 is taken live at scan end.
  always_comb begin
    w_scan  = {~r_row_sync, r_hits};
    w_count = 5'd0;
    w_idx   = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (w_scan[i]) begin
        w_count = w_count + 5'd1;
        w_idx   = 4'(i);
      end
    end
    w_cand = (w_count == 5'd1) ? {1'b1, C_KEY_MAP[w_idx]} : C_CAND_NONE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_row_meta  <= 4'hF;
      r_row_sync  <= 4'hF;
      r_col_idx   <= 2'd0;
      r_div_cnt   <= '0;
      r_hits      <= 12'd0;
      r_cand      <= C_CAND_NONE;
      r_scan_done <= 1'b0;
    end else begin
      r_row_meta  <= row;
      r_row_sync  <= r_row_meta;
      r_scan_done <= 1'b0;
      if (w_slot_end) begin
        r_div_cnt <= '0;
        r_col_idx <= r_col_idx + 2'd1;
        case (r_col_idx)
          2'd0: r_hits[3:0]  <= ~r_row_sync;
          2'd1: r_hits[7:4]  <= ~r_row_sync;
          2'd2: r_hits[11:8] <= ~r_row_sync;
          default: begin
            r_cand      <= w_cand;
            r_scan_done <= 1'b1;
          end
        endcase
      end else begin
        r_div_cnt <= r_div_cnt + C_DIV_ONE;
      end
    end
  end

  keypad_debounce #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_debounce (
    .clk       (clk),
    .reset     (reset),
    .scan_done (r_scan_done),
    .candidate (r_cand),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
// tb_keypad_scanner - randomized keypad stimulus against a scan-level model (rev 1.0)
// ============================================================================
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 3;
  localparam int SCAN_CYC = 4 * SCAN_DIV;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [3:0][3:0] pressed;   // pressed[r][c]
  logic [3:0] layout [4][4] = '{'{4'h1, 4'h2, 4'h3, 4'hA},
                                '{4'h4, 4'h5, 4'h6, 4'hB},
                                '{4'h7, 4'h8, 4'h9, 4'hC},
                                '{4'h0, 4'hF, 4'hE, 4'hD}};

  int n_checks = 0;
  int n_pass   = 0;

  logic [4:0] hist [$];
  logic       m_held;
  logic [3:0] m_code;
  logic       m_valid;
  bit         pend;

  always #5 clk = ~clk;

  keypad_scanner #(
    .SCAN_DIV      (SCAN_DIV),
    .DEBOUNCE_SCANS(DEB)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .row      (row),
    .col      (col),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  // Passive matrix: a row is pulled low by any pressed key whose column is driven.
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      row[r] = 1'b1;
      for (int c = 0; c < 4; c++) begin
        if (pressed[r][c] && !col[c]) row[r] = 1'b0;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] expected);
    n_checks++;
    if (got === expected) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, expected, $time);
  endtask

  function automatic logic [15:0] key_of(input logic [3:0] code);
    logic [15:0] k = 16'd0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (layout[r][c] == code) k[r*4+c] = 1'b1;
    return k;
  endfunction

  function automatic logic [4:0] cand_of(input logic [15:0] keys);
    int n = 0;
    logic [3:0] code = 4'd0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c]) begin
          n++;
          code = layout[r][c];
        end
    return (n == 1) ? {1'b1, code} : 5'b0;
  endfunction

  task automatic model_reset();
    hist.delete();
    m_held  = 1'b0;
    m_code  = 4'd0;
    m_valid = 1'b0;
    pend    = 1'b0;
  endtask

  // Stable means the last DEB scan results (since reset) were identical.
  task automatic model_decide();
    bit stable;
    logic [4:0] last;
    stable = 1'b0;
    if (hist.size() >= DEB) begin
      stable = 1'b1;
      last = hist[hist.size()-1];
      for (int i = 1; i < DEB; i++)
        if (hist[hist.size()-1-i] != last) stable = 1'b0;
    end
    if (stable) begin
      if (!m_held && last[4]) begin
        m_held = 1'b1; m_code = last[3:0]; m_valid = 1'b1;
      end else if (m_held && !last[4]) begin
        m_held = 1'b0;
      end else if (m_held && last[3:0] != m_code) begin
        m_code = last[3:0]; m_valid = 1'b1;
      end
    end
  endtask

  task automatic run_scan(input logic [15:0] keys);
    logic [3:0] col_exp;
    pressed = keys;
    for (int t = 0; t < SCAN_CYC; t++) begin
      @(posedge clk);
      #1;
      m_valid = 1'b0;
      if (t == 0 && pend) begin
        model_decide();
        pend = 1'b0;
      end
      col_exp = 4'b0001 << (((t + 1) / SCAN_DIV) % 4);
      col_exp = ~col_exp;
      check_eq("col", col, col_exp);
      check_eq("key_valid", key_valid, m_valid);
      check_eq("key_held", key_held, m_held);
      check_eq("key_code", key_code, m_code);
    end
    hist.push_back(cand_of(keys));
    pend = 1'b1;
  endtask

  task automatic run_hold(input logic [15:0] keys, input int scans);
    for (int s = 0; s < scans; s++) run_scan(keys);
  endtask

  initial begin
    logic [15:0] cur;
    int remain;
    int i, j;

    pressed = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_eq("rst_col", col, 4'hE);
    check_eq("rst_valid", key_valid, 1'b0);
    check_eq("rst_held", key_held, 1'b0);
    check_eq("rst_code", key_code, 4'h0);
    reset = 1'b1;

    run_hold(16'd0, 4);
    run_hold(key_of(4'h5), 6);
    run_hold(16'd0, 5);
    for (int s = 0; s < 6; s++) run_scan((s % 2 == 0) ? key_of(4'h9) : 16'd0);
    run_hold(key_of(4'h9), 5);
    run_hold(16'd0, 4);
    run_hold(key_of(4'hA), 4);
    run_hold(key_of(4'hA) | key_of(4'hD), 4);
    run_hold(key_of(4'hD), 5);
    run_hold(16'd0, 4);

    cur = 16'd0;
    remain = 0;
    for (int s = 0; s < 80; s++) begin
      if (remain == 0) begin
        case ($urandom_range(0, 3))
          0: cur = 16'd0;
          1, 2: cur = 16'd1 << $urandom_range(0, 15);
          default: begin
            i = $urandom_range(0, 15);
            j = (i + $urandom_range(1, 15)) % 16;
            cur = (16'd1 << i) | (16'd1 << j);
          end
        endcase
        remain = $urandom_range(1, 5);
      end
      run_scan(cur);
      remain--;
    end

    run_hold(key_of(4'hD), 4);
    run_hold(key_of(4'h1), 2);
    repeat (5) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check_eq("midrst_col", col, 4'hE);
    check_eq("midrst_valid", key_valid, 1'b0);
    check_eq("midrst_held", key_held, 1'b0);
    check_eq("midrst_code", key_code, 4'h0);
    @(negedge clk);
    @(negedge clk);
    model_reset();
    reset = 1'b1;
    run_hold(key_of(4'h1), 5);
    run_hold(16'd0, 5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/keypad_scanner.md
# keypad_scanner

Input-side counterpart of the multiplexed 7-segment driver. The driver scans anodes outward; this block scans the columns of a 4x4 matrix keypad (Pmod KYPD style) and reads its rows back. It debounces the result and rejects multi-key presses. It delivers a 4-bit hex key code with a one-cycle valid strobe, ready to feed the display path as its value source.

## Interface
- SCAN_DIV, default 100000: clock cycles each column is driven (1 ms at 100 MHz); legal minimum 4.
- DEBOUNCE_SCANS, default 4: consecutive identical full scans required to accept a press or a release; legal range 2..15.
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- row  input  4  keypad rows, active-low, externally pulled up; asynchronous to clk.
- col  output  4  keypad column drive, active-low one-hot.
- key_code  output  4  hex code of the accepted key.
- key_valid  output  1  one-cycle pulse when a new key is accepted.
- key_held  output  1  high while an accepted key remains stably pressed.

## Operation
- row passes through a 2-flop synchronizer before any use.
- Column sequencer:
  - col index c cycles 0,1,2,3,0,… and col = ~(1<<c).
  - A divider counts 0..SCAN_DIV-1 per column.
  - The synchronized row is sampled on the last count of each slot.
- Key map (c = column, r = row, r0 = top):
  - c0: 1,4,7,0
  - c1: 2,5,8,F
  - c2: 3,6,9,E
  - c3: A,B,C,D
- Scan result, evaluated at the end of the c3 slot over all 16 sampled bits:
  - exactly one pressed → candidate = mapped code;
  - zero pressed → candidate = NONE;
  - two or more pressed → candidate = NONE (ghost reject).
- Debounce:
  - A match counter (4 bits) increments when the candidate equals the previous scan's candidate and saturates at DEBOUNCE_SCANS.
  - It resets to 1 when the candidate differs from the previous scan's.
  - The candidate is "stable" when the counter reaches DEBOUNCE_SCANS.
- Debounce FSM states and transitions:
  - RELEASED: on a stable key K → PRESSED; latch key_code=K, pulse key_valid, set key_held.
  - PRESSED with a stable NONE → RELEASED; clear key_held; key_code holds its last value.
  - PRESSED with a stable key K' ≠ key_code → stays PRESSED; latch K', pulse key_valid again (direct key change).
  - PRESSED with a stable key equal to key_code → no action; no repeat pulses.
- Boundaries:
  - A candidate that flickers back and forth never reaches stable, so no event fires.
  - While a multi-key combination persists, the block sees a stable NONE and releases.
  - Reset mid-scan restarts at c0, count 0, match counter 0, state RELEASED.

## Timing
- Reset values:
  - col=4'b1110, key_code=0, key_valid=0, key_held=0.
  - Synchronizer flops = 4'b1111, state RELEASED.
- One full scan is 4*SCAN_DIV cycles. The scan-end boundary is the clock edge that ends the c3 slot.
- key_valid and key_held update on the clock edge after the scan-end boundary at which the candidate becomes stable.
  - key_valid is high for exactly that one cycle.
  - key_code changes on that same edge.
- Press latency: a key held from the start of a scan is accepted DEBOUNCE_SCANS scans later, plus 1 cycle.
- Release latency is the same number of scans.
- Settling: the row sample is taken SCAN_DIV-1 cycles after the column switches. With the 2-flop synchronizer, SCAN_DIV ≥ 4 guarantees a valid sample.

## Structure
- Package keypad_pkg holds:
  - the 16-entry key-map constant indexed {c,r};
  - the NONE encoding for the 5-bit candidate (valid bit + code);
  - the FSM state enum.
- Sub-module keypad_debounce: takes candidate + scan_done and contains the match counter, the FSM, key_code, key_valid and key_held.
- The top level holds the synchronizer, column sequencer and scan accumulator.

## Test plan
All scenarios use SCAN_DIV=4 and DEBOUNCE_SCANS=3, with a bench keypad model that drives row[r]=0 while col[c]=0 and key (r,c) is pressed.
- Reset release, no keys:
  - col sequence 1110,1101,1011,0111 repeats, 4 cycles each;
  - key_valid never pulses; key_held=0.
- Press key 5 (r1,c1) and hold 6 scans:
  - exactly one key_valid pulse with key_code=4'h5, 3 scans plus 1 cycle after the first full scan containing it;
  - key_held=1 from that pulse onward.
- Release after the previous scenario:
  - key_held falls 3 scans after release; no key_valid pulse;
  - key_code stays 4'h5.
- Bounce: toggle key 9 every scan for 6 scans, then hold →
  - no pulse during toggling;
  - one pulse with key_code=4'h9 after 3 stable scans.
- Hold A, then press D as well for 4 scans, then release A while D stays held:
  - pulse with code A;
  - the A+D overlap acts as NONE, so key_held drops;
  - then a pulse with code D.
- Assert reset mid-press (key 1 held, counter=2) →
  - all outputs at reset values immediately;
  - after reset release, a fresh pulse with code 4'h1 after 3 scans.
